// File: rtl/prod_pkg.sv
// prod_pkg: shared state encoding, timing constants and default address map for prod_engine.
package prod_pkg;
    typedef enum logic [3:0] {RD0, RD1, RD2, RD3, MUL, WR0, WR1, WR2, WR3, DONE} state_t;
    localparam int MUL_CYCLES = 16;
    localparam int BYTES_PER_PAIR = 4;
    localparam int NUM_PAIRS_DEF = 16;
    localparam int SRC_BASE_DEF = 0;
    localparam int DST_BASE_DEF = 64;
    localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/booth_mul16.sv
// booth_mul16: sequential radix-2 Booth multiplier, p = a*b signed, one step per cycle.
module booth_mul16
    import prod_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p,
    output logic               ready
);
    logic signed [15:0] m;
    logic signed [15:0] acc;
    logic [15:0]        q;
    logic               q1;
    logic [4:0]         cnt;
    logic signed [16:0] sum;

    // 17-bit sum keeps the -32768 multiplicand case exact before the arithmetic shift
    always_comb begin
        sum = (q[0] && !q1) ? {acc[15], acc} - {m[15], m} :
              (!q[0] && q1) ? {acc[15], acc} + {m[15], m} : {acc[15], acc};
        p = {acc, q};
        ready = cnt == 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            q1  <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            m   <= a;
            acc <= '0;
            q   <= b;
            q1  <= 1'b0;
            cnt <= 5'(MUL_CYCLES);
        end else if (cnt != 5'd0) begin
            acc <= sum[16:1];
            q   <= {sum[0], q[15:1]};
            q1  <= q[0];
            cnt <= cnt - 5'd1;
        end
    end
endmodule

// File: rtl/prod_engine.sv
// prod_engine: reads signed 16-bit operand pairs from data memory, multiplies them
// and writes the 32-bit products back big-endian, then raises done until reset.
module prod_engine
    import prod_pkg::*;
#(
    parameter int NUM_PAIRS = NUM_PAIRS_DEF,
    parameter int SRC_BASE  = SRC_BASE_DEF,
    parameter int DST_BASE  = DST_BASE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              done
);
    localparam int PW = NUM_PAIRS > 1 ? $clog2(NUM_PAIRS) : 1;

    state_t             state, next;
    logic [PW-1:0]      pair;
    logic [7:0]         a_hi, a_lo, b_hi;
    logic               start, ready, is_rd, is_wr, last;
    logic [1:0]         k;
    logic [ADDR_W-1:0]  off;
    logic signed [31:0] p;

    booth_mul16 u_mul (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     ($signed({a_hi, a_lo})),
        .b     ($signed({b_hi, mem_rd_data})),
        .p     (p),
        .ready (ready)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RD0;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            RD0:     next = RD1;
            RD1:     next = RD2;
            RD2:     next = RD3;
            RD3:     next = MUL;
            MUL:     next = ready ? WR0 : MUL;
            WR0:     next = WR1;
            WR1:     next = WR2;
            WR2:     next = WR3;
            WR3:     next = last ? DONE : RD0;
            DONE:    next = DONE;
            default: next = RD0;
        endcase
    end

    // the low operand byte goes straight into the multiplier as it loads in RD3
    always_ff @(posedge clk) begin
        if (reset) begin
            pair <= '0;
            a_hi <= '0;
            a_lo <= '0;
            b_hi <= '0;
        end else begin
            if (state == RD0) a_hi <= mem_rd_data;
            if (state == RD1) a_lo <= mem_rd_data;
            if (state == RD2) b_hi <= mem_rd_data;
            if (state == WR3 && !last) pair <= pair + 1'b1;
        end
    end

    always_comb begin
        last = pair == PW'(NUM_PAIRS - 1);
        is_rd = state inside {RD0, RD1, RD2, RD3};
        is_wr = state inside {WR0, WR1, WR2, WR3};
        k = is_wr ? 2'(state - WR0) : 2'(state - RD0);
        off = ADDR_W'({pair, k});
        start = state == RD3;
        done = state == DONE;
        mem_addr = is_rd ? ADDR_W'(SRC_BASE) + off :
                   is_wr ? ADDR_W'(DST_BASE) + off : ADDR_W'(SRC_BASE);
        mem_wr_en = is_wr && !reset;
        mem_wr_data = !is_wr   ? 8'h00 :
                      k == 2'd0 ? p[31:24] :
                      k == 2'd1 ? p[23:16] :
                      k == 2'd2 ? p[15:8] : p[7:0];
    end
endmodule

// File: tb/tb_prod_engine.sv
// tb_prod_engine: byte memory model plus golden products computed from plain signed arithmetic.
module tb_prod_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic       mem_wr_en, done;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];
    logic [7:0]  src_copy [64];
    logic [15:0] a_img [16];
    logic [15:0] b_img [16];
    int total = 0, bad = 0, wr_idx = 0;

    typedef struct {logic [15:0] a; logic [15:0] b; logic [31:0] p;} vec_t;
    vec_t tbl [6];

    prod_engine dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .done        (done)
    );

    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // every write must target the next product byte in order, with the golden value
    always @(negedge clk) if (mem_wr_en) begin
        chk("wr_in_reset", 32'(reset), 32'd0);
        chk("wr_addr", 32'(mem_addr), 32'(64 + wr_idx));
        chk("wr_data", 32'(mem_wr_data), 32'(exp_mem[mem_addr]));
        wr_idx++;
    end

    task automatic build(input bit clear_dst);
        for (int i = 0; i < 16; i++) begin
            int x;
            logic [31:0] pv;
            x = int'($signed(a_img[i])) * int'($signed(b_img[i]));
            pv = x;
            mem[4*i] = a_img[i][15:8];
            mem[4*i+1] = a_img[i][7:0];
            mem[4*i+2] = b_img[i][15:8];
            mem[4*i+3] = b_img[i][7:0];
            for (int j = 0; j < 4; j++) begin
                exp_mem[64+4*i+j] = pv[31-8*j -: 8];
                if (clear_dst) mem[64+4*i+j] = 8'h5A;
            end
        end
        for (int i = 0; i < 64; i++) src_copy[i] = mem[i];
    endtask

    task automatic run(input string nm);
        int n;
        n = 0;
        wr_idx = 0;
        @(negedge clk);
        reset = 1'b0;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk({nm, "_done_edge"}, 32'(n), 32'd384);
        chk({nm, "_writes"}, 32'(wr_idx), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk({nm, "_prod"}, 32'(mem[64+i]), 32'(exp_mem[64+i]));
            chk({nm, "_src"}, 32'(mem[i]), 32'(src_copy[i]));
        end
    endtask

    initial begin
        tbl[0] = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[1] = '{16'h0001, 16'hFFFF, 32'hFFFFFFFF};
        tbl[2] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        tbl[3] = '{16'h0003, 16'hFFFB, 32'hFFFFFFF1};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr_data", 32'(mem_wr_data), 32'd0);

        for (int i = 0; i < 16; i++) begin a_img[i] = 16'h0; b_img[i] = 16'h0; end
        build(1'b1);
        run("zeros");

        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_img[i] = i < 6 ? tbl[i].a : 16'h0;
            b_img[i] = i < 6 ? tbl[i].b : 16'h0;
        end
        build(1'b1);
        run("directed");
        for (int i = 0; i < 6; i++) begin
            logic [31:0] got;
            got = {mem[64+4*i], mem[65+4*i], mem[66+4*i], mem[67+4*i]};
            chk("table_prod", got, tbl[i].p);
        end

        for (int r = 0; r < 2; r++) begin
            @(negedge clk) reset = 1'b1;
            for (int i = 0; i < 16; i++) begin
                a_img[i] = 16'($urandom);
                b_img[i] = 16'($urandom);
            end
            build(1'b1);
            run("random");
        end

        // abort mid-run: pairs 0..3 are already stored, pair 4 is in the multiplier
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_img[i] = 16'($urandom);
            b_img[i] = 16'($urandom);
        end
        build(1'b1);
        wr_idx = 0;
        @(negedge clk) reset = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("midrst_done", 32'(done), 32'd0);
            chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        end
        chk("midrst_partial", 32'(mem[79]), 32'(exp_mem[79]));
        chk("midrst_untouched", 32'(mem[80]), 32'h5A);
        run("rerun");

        repeat (50) @(negedge clk);
        chk("done_held", 32'(done), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_img[i] = 16'($urandom);
            b_img[i] = 16'($urandom);
        end
        build(1'b0);
        @(posedge clk);
        #1;
        chk("done_drop", 32'(done), 32'd0);
        run("second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prod_engine.md
Name: prod_engine

Overview:
- Hardware coprocessor that performs the product pass without running the program.
- Walks data memory and reads 16 operand pairs of signed 16-bit values from bytes 0..63.
- Forms each 32-bit two's-complement product with a sequential Booth multiplier.
- Writes results big-endian to bytes 64..127, then raises done.
- Sits beside top_level on the byte-wide data memory port (dm1). Downstream consumer of the operand image that the bench loads.

Parameters:
- NUM_PAIRS, 16, number of operand pairs processed per run
- SRC_BASE, 0, byte address of first operand
- DST_BASE, 64, byte address of first product
- ADDR_W, 8, data memory address width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; also serves as start request (run begins when it falls)
- mem_addr  output  ADDR_W  data memory byte address
- mem_rd_data  input  8  data memory read data, combinational (asynchronous read) from mem_addr
- mem_wr_en  output  1  data memory write enable, written at rising edge
- mem_wr_data  output  8  data memory write data
- done  output  1  run complete; held until reset

Behaviour:
- Reset:
  - state=RD0, pair=0, done=0, mem_wr_en=0, mem_addr=SRC_BASE, mem_wr_data=0.
  - While reset is high the block holds there and issues no writes.
- Pair j (0..NUM_PAIRS-1):
  - A = {mem[SRC_BASE+4j], mem[+4j+1]}.
  - B = {mem[+4j+2], mem[+4j+3]}.
  - P = B*A, signed 32-bit; never overflows, since -32768*-32768 = 2^30.
- States, one byte or step per cycle:
  - RD0..RD3: mem_addr = SRC_BASE+4j+k, mem_rd_data latched into A_hi, A_lo, B_hi, B_lo at cycle end.
  - MUL: exactly 16 cycles; radix-2 Booth on a 33-bit {acc, B, q-1} register with arithmetic right shift.
  - WR0..WR3: mem_addr = DST_BASE+4j+k, mem_wr_en=1, mem_wr_data = P[31:24], P[23:16], P[15:8], P[7:0] respectively (MSB first).
  - After WR3: if j==NUM_PAIRS-1, go to DONE; else j++ and go to RD0.
  - DONE: mem_wr_en=0, done=1, mem_addr=SRC_BASE; stays there until reset.
- Latency:
  - 24 cycles per pair.
  - done is first high after the 384th rising edge following the first edge sampled with reset low.
- mem_wr_en and mem_addr are combinational from state and counters; mem_wr_en=0 in every non-WR state.
- Reset mid-run:
  - Next edge returns to RD0, pair 0, done=0; the in-flight write is abandoned.
  - Products already written stay in memory; a following run overwrites them.
- Reset asserted while in DONE: done drops on that edge.
- Source bytes 0..63 are never written.
- DST_BASE+4*NUM_PAIRS-1 must be below 2^ADDR_W; at defaults the last write goes to address 127.

Decomposition:
- prod_pkg holds:
  - state enum (RD0, RD1, RD2, RD3, MUL, WR0, WR1, WR2, WR3, DONE)
  - MUL_CYCLES=16, BYTES_PER_PAIR=4
  - default base addresses
- Sub-module booth_mul16:
  - Inputs: clk, reset, start, signed 16-bit a and b.
  - Outputs: signed 32-bit p and a ready pulse.
  - Ready asserts 16 cycles after start.
  - prod_engine waits on ready, not on a duplicated counter.

Test Plan:
- All 64 source bytes zero, release reset -> bytes 64..127 all 0x00; done rises at edge 384, not edge 383.
- Pair 0 A=0x8000, B=0x8000 -> mem[64..67] = 40 00 00 00; pair 1 A=0x0001, B=0xFFFF -> mem[68..71] = FF FF FF FF.
- Pair 2 A=0x7FFF, B=0x8000 -> mem[72..75] = C0 00 80 00 (-1073709056); pair 3 A=0x0003, B=0xFFFB -> FF FF FF F1 (-15).
- Random signed pairs, all 16 checked against a golden 32-bit product -> 16/16 match; monitor shows mem_wr_en only at addresses 64..127, exactly 64 writes, MSB first.
- Assert reset at cycle 100 of a run, release 3 cycles later -> done=0 during reset, no writes while reset is high; rerun completes 384 cycles after release with correct products.
- After done, hold 50 cycles, then pulse reset with a new operand image -> done drops on the reset edge; second run produces the new products; source bytes unchanged.
